// File: rtl/rv_uart_top_core.sv
// UART stream/benchmark engine: receives a length, streams ack-paced words, then reports the transfer cycle count.
// Also drives the board status outputs: LEDs, scanned seven-segment display, clk/2 and idle SPI pins.
module rv_uart_top_core #(
    parameter int          CLKS_PER_BIT = 32,
    parameter int          SCAN_BITS    = 14,
    parameter logic [95:0] KEY_REF      = 96'h3cf3cf3cf3cf_30c30c_bae_3cf
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        rx,
    output logic        tx,
    input  logic        prog,
    input  logic        debug,
    input  logic [4:0]  debug_input,
    input  logic [95:0] key,
    input  logic        miso,
    output logic        mosi,
    output logic        cs,
    output logic        clk_out,
    output logic [6:0]  sev_out,
    output logic [7:0]  an,
    output logic [15:0] led
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {S_IDLE, S_GET_LEN, S_SEND_WORD, S_WAIT_ACK, S_SEND_CNT} state_t;

    state_t         state, next_state;
    logic           rx_s1, rx_s2, rx_d, rx_busy, rx_valid, frame_err;
    logic [CW-1:0]  rx_cnt, tx_cnt;
    logic [3:0]     rx_bit, tx_bit;
    logic [7:0]     rx_shift, rx_data, last_rx, tx_byte;
    logic           tx_busy, tx_ready, tx_start, len_done, key_ok;
    logic [8:0]     tx_shift;
    logic [1:0]     byte_sel;
    logic [31:0]    len_n, idx, count, len_next, disp_val;
    logic [SCAN_BITS-1:0] scan_cnt;
    logic [2:0]     digit;
    logic [3:0]     nibble;
    logic [6:0]     seg_on;

    // Receiver: bit 0 is the start bit (checked at half a bit), bits 1..8 data, bit 9 the stop sample.
    always_ff @(posedge clk) begin
        if (Rst) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_d      <= 1'b1;
            rx_busy   <= 1'b0;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_d     <= rx_s2;
            rx_valid <= 1'b0;
            if (!rx_busy) begin
                if (rx_d && !rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= '0;
                    rx_bit  <= '0;
                end
            end else if (rx_bit == 4'd0) begin
                if (rx_cnt == HALF) begin
                    rx_cnt <= '0;
                    if (rx_s2) rx_busy <= 1'b0;
                    else       rx_bit  <= 4'd1;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
            end else if (rx_cnt == FULL) begin
                rx_cnt <= '0;
                if (rx_bit == 4'd9) begin
                    rx_busy <= 1'b0;
                    if (rx_s2) begin
                        rx_valid <= 1'b1;
                        rx_data  <= rx_shift;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 1'b1;
                end
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    // Accepting a new byte in the final stop-bit cycle keeps consecutive frames gap-free.
    assign tx_ready = !tx_busy || (tx_bit == 4'd9 && tx_cnt == FULL);

    always_ff @(posedge clk) begin
        if (Rst) begin
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
        end else if (tx_start) begin
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= {1'b1, tx_byte};
        end else if (tx_busy) begin
            if (tx_cnt == FULL) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx      <= 1'b1;
                end else begin
                    tx       <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[8:1]};
                    tx_bit   <= tx_bit + 1'b1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) state <= S_IDLE;
        else     state <= next_state;
    end

    assign len_next = {rx_data, len_n[31:8]};
    assign len_done = (state == S_GET_LEN) && rx_valid && (byte_sel == 2'd3) && !prog;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (rx_valid && rx_data == 8'h01) next_state = S_GET_LEN;
            S_GET_LEN:   if (len_done) next_state = (len_next == 32'd0) ? S_SEND_CNT : S_SEND_WORD;
            S_SEND_WORD: if (tx_start && byte_sel == 2'd3) next_state = S_WAIT_ACK;
            S_WAIT_ACK:  if (rx_valid) begin
                             if (rx_data == 8'h00 && idx + 32'd1 == len_n) next_state = S_SEND_CNT;
                             else                                          next_state = S_SEND_WORD;
                         end
            S_SEND_CNT:  if (tx_start && byte_sel == 2'd3) next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
        if (prog) next_state = S_IDLE;
    end

    always_comb begin
        tx_start = 1'b0;
        tx_byte  = 8'h00;
        case (state)
            S_SEND_WORD: begin
                tx_start = tx_ready && !prog;
                tx_byte  = idx[{byte_sel, 3'b000} +: 8];
            end
            S_SEND_CNT: begin
                tx_start = tx_ready && !prog;
                tx_byte  = count[{byte_sel, 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    // byte_sel restarts on every state change, so each state sees its bytes numbered from 0.
    always_ff @(posedge clk) begin
        if (Rst) begin
            byte_sel <= '0;
            len_n    <= '0;
            idx      <= '0;
            count    <= '0;
            last_rx  <= '0;
            key_ok   <= 1'b0;
            clk_out  <= 1'b0;
            scan_cnt <= '0;
            digit    <= '0;
            an       <= 8'hFE;
        end else begin
            if (state != next_state)
                byte_sel <= '0;
            else if ((state == S_GET_LEN && rx_valid) || tx_start)
                byte_sel <= byte_sel + 1'b1;
            if (state == S_GET_LEN && rx_valid) len_n <= len_next;
            if (len_done) begin
                idx   <= '0;
                count <= '0;
            end else begin
                if (state == S_WAIT_ACK && rx_valid && rx_data == 8'h00 && !prog) idx <= idx + 32'd1;
                if ((state == S_SEND_WORD || state == S_WAIT_ACK) && count != 32'hFFFF_FFFF)
                    count <= count + 32'd1;
            end
            if (rx_valid) last_rx <= rx_data;
            key_ok   <= (key == KEY_REF);
            clk_out  <= ~clk_out;
            scan_cnt <= scan_cnt + 1'b1;
            if (&scan_cnt) begin
                digit <= digit + 1'b1;
                an    <= {an[6:0], an[7]};
            end
        end
    end

    always_comb begin
        disp_val = count;
        if (debug) begin
            case (debug_input)
                5'd0:    disp_val = len_n;
                5'd1:    disp_val = idx;
                5'd2:    disp_val = count;
                5'd3:    disp_val = {24'd0, last_rx};
                default: disp_val = 32'd0;
            endcase
        end
    end

    assign nibble = disp_val[{digit, 2'b00} +: 4];

    always_comb begin
        case (nibble)
            4'h0: seg_on = 7'h3F;
            4'h1: seg_on = 7'h06;
            4'h2: seg_on = 7'h5B;
            4'h3: seg_on = 7'h4F;
            4'h4: seg_on = 7'h66;
            4'h5: seg_on = 7'h6D;
            4'h6: seg_on = 7'h7D;
            4'h7: seg_on = 7'h07;
            4'h8: seg_on = 7'h7F;
            4'h9: seg_on = 7'h6F;
            4'hA: seg_on = 7'h77;
            4'hB: seg_on = 7'h7C;
            4'hC: seg_on = 7'h39;
            4'hD: seg_on = 7'h5E;
            4'hE: seg_on = 7'h79;
            default: seg_on = 7'h71;
        endcase
    end

    assign sev_out = ~seg_on;
    assign led     = {last_rx, 5'b00000, frame_err, state != S_IDLE, key_ok};
    assign cs      = 1'b1;
    // The SPI port is parked; folding miso into the constant gives it a load.
    assign mosi    = miso | 1'b1;
endmodule

// File: tb/tb_rv_uart_top_core.sv
// Self-checking bench for rv_uart_top_core: UART host model, tx frame monitor and a byte-stream reference model.
module tb_rv_uart_top_core;
    localparam int          CPB     = 32;
    localparam logic [95:0] KEY_REF = 96'h3cf3cf3cf3cf_30c30c_bae_3cf;

    logic        clk, Rst, rx, tx, prog, debug, miso, mosi, cs, clk_out;
    logic [4:0]  debug_input;
    logic [95:0] key;
    logic [6:0]  sev_out;
    logic [7:0]  an;
    logic [15:0] led;

    int tests_run = 0, tests_failed = 0, cyc = 0, tx_stop_err = 0, cnt_meas = 0;
    logic [7:0] rxq[$];
    logic [7:0] ack_plan[$];
    logic [7:0] mon_byte;
    logic [6:0] seg_tab [16];

    typedef struct {
        logic [95:0] key;
        logic        dbg;
        logic [4:0]  dsel;
        logic        exp_led0;
        logic [31:0] exp_disp;
        int          tol;
        string       name;
    } vec_t;
    vec_t vec [8];

    rv_uart_top_core #(.CLKS_PER_BIT(CPB), .SCAN_BITS(4), .KEY_REF(KEY_REF)) dut (
        .clk(clk), .Rst(Rst), .rx(rx), .tx(tx), .prog(prog), .debug(debug),
        .debug_input(debug_input), .key(key), .miso(miso), .mosi(mosi), .cs(cs),
        .clk_out(clk_out), .sev_out(sev_out), .an(an), .led(led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        repeat (90000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "[TB] watchdog");
    end

    // Host-side receiver: samples each tx bit in its middle, on the falling clock edge.
    initial begin
        forever begin
            @(negedge tx);
            repeat (CPB / 2) @(negedge clk);
            if (tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mon_byte[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) tx_stop_err++;
                rxq.push_back(mon_byte);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input logic [31:0] act, input logic [31:0] exp, input int tol);
        logic [31:0] diff;
        tests_run++;
        diff = (act > exp) ? act - exp : exp - act;
        if ($isunknown(act) || diff > 32'(tol)) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (+/-%0d)", name, act, exp, tol);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input bit stop_val);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_val;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_rx_count(input string name, input int target, input int budget, output bit ok);
        int w;
        w = 0;
        while (rxq.size() < target && w < budget) begin
            @(negedge clk);
            w++;
        end
        ok = (rxq.size() >= target);
        if (!ok) check(name, rxq.size(), target);
    endtask

    task automatic read_display(output logic [31:0] v);
        v = '0;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] want;
            logic [3:0] nib;
            int w;
            want = ~(8'b1 << k);
            w = 0;
            while (an !== want && w < 400) begin
                @(negedge clk);
                w++;
            end
            nib = 4'hx;
            if (an === want)
                for (int j = 0; j < 16; j++)
                    if (sev_out === ~seg_tab[j]) nib = 4'(j);
            v[4*k +: 4] = nib;
        end
    endtask

    // Reference model: word i goes out as i LSB-first; a nonzero ack repeats it; the count spans
    // from accepting the last length byte to accepting the final zero ack.
    task automatic run_transfer(input string name, input int n);
        int widx, got, t0, t1;
        bit ok;
        logic [7:0] ack;
        logic [7:0] exp_q[$];
        logic [31:0] cnt_rx;
        rxq.delete();
        apply_stimulus(8'h01, 1'b1);
        t0 = 0;
        for (int b = 0; b < 4; b++) begin
            if (b == 3) t0 = cyc;
            apply_stimulus(8'(n >> (8 * b)), 1'b1);
        end
        t1 = t0;
        widx = 0;
        got = 0;
        while (widx < n) begin
            for (int b = 0; b < 4; b++) exp_q.push_back(8'(widx >> (8 * b)));
            wait_rx_count({name, "_word_timeout"}, got + 4, 4000, ok);
            if (!ok) return;
            got += 4;
            if (ack_plan.size() > 0) ack = ack_plan.pop_front();
            else ack = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            if (ack == 8'h00 && widx == n - 1) t1 = cyc;
            apply_stimulus(ack, 1'b1);
            if (ack == 8'h00) widx++;
        end
        wait_rx_count({name, "_count_timeout"}, got + 4, 4000, ok);
        if (!ok) return;
        for (int i = 0; i < got; i++) check({name, "_data"}, rxq[i], exp_q[i]);
        cnt_rx = {rxq[got+3], rxq[got+2], rxq[got+1], rxq[got]};
        cnt_meas = t1 - t0;
        if (n == 0) check({name, "_count"}, cnt_rx, 32'd0);
        else        check_near({name, "_count"}, cnt_rx, 32'(cnt_meas), 2);
        repeat (CPB * 12) @(negedge clk);
        check({name, "_byte_total"}, rxq.size(), got + 4);
        check({name, "_idle"}, led[1], 1'b0);
    endtask

    initial begin
        int tx_bad, an_bad, seq_bad, clk_bad, n_main;
        bit ok;
        logic [7:0] prev_an;
        logic prev_clk;
        logic [31:0] v;
        logic [95:0] kflip;

        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        Rst = 1'b1; rx = 1'b1; prog = 1'b0; debug = 1'b0; debug_input = 5'd0;
        key = '0; miso = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_led", led, 16'h0000);
        check("reset_an", an, 8'hFE);
        check("reset_clk_out", clk_out, 1'b0);
        check("reset_spi", {cs, mosi}, 2'b11);
        Rst = 1'b0;
        rxq.delete();

        tx_bad = 0; an_bad = 0; seq_bad = 0; clk_bad = 0;
        prev_an = an; prev_clk = clk_out;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_bad++;
            if (!$onehot(~an)) an_bad++;
            if (an !== prev_an && an !== {prev_an[6:0], prev_an[7]}) seq_bad++;
            if (clk_out === prev_clk) clk_bad++;
            prev_an = an; prev_clk = clk_out;
        end
        check("idle_tx_high", tx_bad, 0);
        check("idle_an_onehot", an_bad, 0);
        check("idle_an_rotation", seq_bad, 0);
        check("idle_clk_out_toggle", clk_bad, 0);
        check("idle_no_frames", rxq.size(), 0);
        check("idle_led1", led[1], 1'b0);

        run_transfer("n0", 0);

        apply_stimulus(8'h01, 1'b0);
        repeat (CPB * 2) @(negedge clk);
        check("frame_err_led2", led[2], 1'b1);
        check("frame_err_not_accepted", led[1], 1'b0);
        apply_stimulus(8'h07, 1'b1);
        repeat (CPB) @(negedge clk);
        check("cmd07_ignored", led[1], 1'b0);
        check("cmd07_last_rx", led[15:8], 8'h07);

        ack_plan.delete();
        ack_plan.push_back(8'h55);
        ack_plan.push_back(8'h00);
        ack_plan.push_back(8'h00);
        run_transfer("retx", 2);

        n_main = $urandom_range(3, 8);
        run_transfer("rand", n_main);

        apply_stimulus(8'hA7, 1'b1);
        repeat (CPB) @(negedge clk);
        check("stray_ignored", led[1], 1'b0);
        check("stray_last_rx", led[15:8], 8'hA7);

        kflip = KEY_REF ^ (96'd1 << $urandom_range(0, 95));
        vec[0] = '{KEY_REF,           1'b0, 5'd0,  1'b1, 32'(cnt_meas), 2, "disp_count"};
        vec[1] = '{KEY_REF ^ 96'd1,   1'b1, 5'd0,  1'b0, 32'(n_main),   0, "disp_n"};
        vec[2] = '{{$urandom, $urandom, $urandom}, 1'b1, 5'd1, 1'b0, 32'(n_main), 0, "disp_idx"};
        vec[3] = '{KEY_REF,           1'b1, 5'd2,  1'b1, 32'(cnt_meas), 2, "disp_cnt_sel"};
        vec[4] = '{kflip,             1'b1, 5'd3,  1'b0, 32'h0000_00A7, 0, "disp_last_rx"};
        vec[5] = '{KEY_REF,           1'b1, 5'd4,  1'b1, 32'd0,         0, "disp_sel4"};
        vec[6] = '{96'd0,             1'b1, 5'd31, 1'b0, 32'd0,         0, "disp_sel31"};
        vec[7] = '{KEY_REF,           1'b1, 5'd5,  1'b1, 32'd0,         0, "disp_sel5"};
        for (int i = 0; i < 8; i++) begin
            key = vec[i].key;
            debug = vec[i].dbg;
            debug_input = vec[i].dsel;
            repeat (3) @(negedge clk);
            check({vec[i].name, "_led0"}, led[0], vec[i].exp_led0);
            read_display(v);
            check_near(vec[i].name, v, vec[i].exp_disp, vec[i].tol);
        end
        key = '0; debug = 1'b0;

        rxq.delete();
        apply_stimulus(8'h01, 1'b1);
        apply_stimulus(8'h05, 1'b1);
        for (int b = 0; b < 3; b++) apply_stimulus(8'h00, 1'b1);
        wait_rx_count("prog_first_bytes", 2, 4000, ok);
        prog = 1'b1;
        repeat (4) @(negedge clk);
        check("prog_forces_idle", led[1], 1'b0);
        prog = 1'b0;
        repeat (1500) @(negedge clk);
        check("prog_no_more_bytes", rxq.size(), 2);
        check("prog_idle_after", led[1], 1'b0);

        rxq.delete();
        apply_stimulus(8'h01, 1'b1);
        apply_stimulus(8'h05, 1'b1);
        for (int b = 0; b < 3; b++) apply_stimulus(8'h00, 1'b1);
        wait_rx_count("rst_word0", 4, 4000, ok);
        apply_stimulus(8'h00, 1'b1);
        wait_rx_count("rst_word1", 5, 4000, ok);
        check("rst_word1_byte0", rxq[4], 8'h01);
        Rst = 1'b1;
        @(negedge clk);
        check("rst_tx_high", tx, 1'b1);
        check("rst_led_clear", led, 16'h0000);
        check("rst_an", an, 8'hFE);
        Rst = 1'b0;
        repeat (1500) @(negedge clk);
        check("rst_no_more_bytes", rxq.size(), 5);
        check("rst_idle", led[1], 1'b0);
        check("tx_stop_bits", tx_stop_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
